// File: rtl/mostra_pkg.sv
// Shared definitions for the sequence display block: state codes and default timings.
package mostra_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    ACENDE  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    CARREGA = 4'd5,
    FIM     = 4'd6
  } estado_t;

  localparam int unsigned TEMPO_ACESO_DEF   = 1000;
  localparam int unsigned TEMPO_APAGADO_DEF = 500;
  localparam int unsigned DADO_W            = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mostra_sequencia_if.sv
// Control/ROM/LED bundle of mostra_sequencia. MOSTRA_PAUSA_EN adds the pausa input.
interface mostra_sequencia_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              iniciar;
  logic [ADDR_W-1:0] limite;
  logic [3:0]        mem_dado;
  logic [ADDR_W-1:0] mem_endereco;
  logic [3:0]        leds;
  logic              mostrando;
  logic              pronto;
  logic [3:0]        db_estado;
`ifdef MOSTRA_PAUSA_EN
  logic              pausa;

  modport master (output iniciar, limite, mem_dado, pausa,
                  input  mem_endereco, leds, mostrando, pronto, db_estado);
  modport slave  (input  iniciar, limite, mem_dado, pausa,
                  output mem_endereco, leds, mostrando, pronto, db_estado);
`else
  modport master (output iniciar, limite, mem_dado,
                  input  mem_endereco, leds, mostrando, pronto, db_estado);
  modport slave  (input  iniciar, limite, mem_dado,
                  output mem_endereco, leds, mostrando, pronto, db_estado);
`endif
endinterface

// File: rtl/contador_tempo.sv
// Cycle counter shared by the lit and dark phases; synchronous clear wins over enable.
module contador_tempo #(
  parameter int unsigned M = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_enable,
  output logic [$clog2(M+1)-1:0]   o_count,
  output logic                     o_fim_c
);
  localparam int unsigned W = $clog2(M + 1);

  logic [W-1:0] r_count;

  assign o_fim_c = i_enable && (r_count == W'(M - 1));
  assign o_count = r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_fim_c ? '0 : r_count + W'(1);
    end
  end
endmodule

// File: rtl/mostra_sequencia.sv
// Shows ROM entries 0..limite on the LEDs, lit then dark, then pulses pronto.
// Optional MOSTRA_PAUSA_EN: pausa freezes the lit/dark timing.
module mostra_sequencia
  import mostra_pkg::*;
#(
  parameter int unsigned TEMPO_ACESO   = TEMPO_ACESO_DEF,
  parameter int unsigned TEMPO_APAGADO = TEMPO_APAGADO_DEF,
  parameter int unsigned ADDR_W        = 4
) (
  input logic               clock,
  input logic               reset,
  mostra_sequencia_if.slave bus
);
  localparam int unsigned T_MAX = max_u(TEMPO_ACESO, TEMPO_APAGADO);
  localparam int unsigned T_W   = $clog2(T_MAX + 1);

  estado_t            r_estado, w_prox;
  logic [ADDR_W-1:0]  r_endereco, w_endereco_prox;
  logic [ADDR_W-1:0]  r_limite, w_limite_prox;
  logic [DADO_W-1:0]  r_leds, w_leds_prox;
  logic               r_pronto, r_mostrando;
  logic               w_clear, w_enable, w_pausa;
  logic               w_fim_timer, w_fim_aceso, w_fim_apagado;
  logic [T_W-1:0]     w_count;

`ifdef MOSTRA_PAUSA_EN
  assign w_pausa = bus.pausa;
`else
  assign w_pausa = 1'b0;
`endif

  assign w_enable = ((r_estado == ACENDE) || (r_estado == APAGA)) && !w_pausa;

  contador_tempo #(.M(T_MAX)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_count  (w_count),
    .o_fim_c  (w_fim_timer)
  );

  // The longer phase uses the counter's own terminal flag; the shorter one compares early.
  assign w_fim_aceso   = w_enable && ((TEMPO_ACESO == T_MAX) ? w_fim_timer
                                       : (w_count == T_W'(TEMPO_ACESO - 1)));
  assign w_fim_apagado = w_enable && ((TEMPO_APAGADO == T_MAX) ? w_fim_timer
                                       : (w_count == T_W'(TEMPO_APAGADO - 1)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox          = r_estado;
    w_endereco_prox = r_endereco;
    w_limite_prox   = r_limite;
    w_leds_prox     = r_leds;
    w_clear         = 1'b0;
    case (r_estado)
      INICIAL: begin
        w_leds_prox = '0;
        // Address returns to 0 early so mem_dado is valid for entry 0 during PREPARA.
        if (bus.iniciar) begin
          w_endereco_prox = '0;
          w_prox          = PREPARA;
        end
      end
      PREPARA: begin
        w_endereco_prox = '0;
        w_limite_prox   = bus.limite;
        w_clear         = 1'b1;
        w_leds_prox     = bus.mem_dado;
        w_prox          = ACENDE;
      end
      ACENDE: begin
        if (w_fim_aceso) begin
          w_leds_prox = '0;
          w_clear     = 1'b1;
          w_prox      = APAGA;
        end
      end
      APAGA: begin
        if (w_fim_apagado) begin
          w_clear = 1'b1;
          w_prox  = (r_endereco == r_limite) ? FIM : PROXIMO;
        end
      end
      PROXIMO: begin
        w_endereco_prox = r_endereco + ADDR_W'(1);
        w_prox          = CARREGA;
      end
      CARREGA: begin
        w_leds_prox = bus.mem_dado;
        w_clear     = 1'b1;
        w_prox      = ACENDE;
      end
      FIM: begin
        w_leds_prox = '0;
        w_prox      = INICIAL;
      end
      default: begin
        w_leds_prox = '0;
        w_prox      = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_endereco  <= '0;
      r_limite    <= '0;
      r_leds      <= '0;
      r_pronto    <= 1'b0;
      r_mostrando <= 1'b0;
    end else begin
      r_endereco  <= w_endereco_prox;
      r_limite    <= w_limite_prox;
      r_leds      <= w_leds_prox;
      r_pronto    <= (w_prox == FIM);
      r_mostrando <= (w_prox != INICIAL) && (w_prox != FIM);
    end
  end

  assign bus.mem_endereco = r_endereco;
  assign bus.leds         = r_leds;
  assign bus.pronto       = r_pronto;
  assign bus.mostrando    = r_mostrando;
  assign bus.db_estado    = r_estado;
endmodule

// File: tb/tb_mostra_sequencia.sv
// Directed scoreboard bench for mostra_sequencia (two instances: A=4/B=2 and A=1/B=1).
module tb_mostra_sequencia;
  localparam int unsigned AW = 4;
  localparam int A0 = 4;
  localparam int B0 = 2;
  localparam int A1 = 1;
  localparam int B1 = 1;

  logic clock;
  logic reset;

  mostra_sequencia_if #(.ADDR_W(AW)) bus0 ();
  mostra_sequencia_if #(.ADDR_W(AW)) bus1 ();

  mostra_sequencia #(.TEMPO_ACESO(A0), .TEMPO_APAGADO(B0), .ADDR_W(AW)) dut0 (
    .clock (clock), .reset (reset), .bus (bus0.slave));
  mostra_sequencia #(.TEMPO_ACESO(A1), .TEMPO_APAGADO(B1), .ADDR_W(AW)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1.slave));

  logic [3:0] rom [16];
  assign bus0.mem_dado = rom[bus0.mem_endereco];
  assign bus1.mem_dado = rom[bus1.mem_endereco];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] val;
    int         len;
  } entrada_t;

  entrada_t sb[$];
  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  logic [3:0]    s_leds, s_estado;
  logic [AW-1:0] s_end;
  logic          s_pronto, s_most;

  always_comb begin
    s_leds   = sel ? bus1.leds         : bus0.leds;
    s_estado = sel ? bus1.db_estado    : bus0.db_estado;
    s_end    = sel ? bus1.mem_endereco : bus0.mem_endereco;
    s_pronto = sel ? bus1.pronto       : bus0.pronto;
    s_most   = sel ? bus1.mostrando    : bus0.mostrando;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ini(input logic v);
    if (sel) bus1.iniciar = v;
    else     bus0.iniciar = v;
  endtask

  task automatic set_lim(input logic [AW-1:0] v);
    if (sel) bus1.limite = v;
    else     bus0.limite = v;
  endtask

  // Pushes the expected entries, optionally starts the DUT, then monitors until back in INICIAL.
  task automatic run_seq(input bit pulse, input bit hold, input int lim,
                         input int ta, input int tb, input int pause_at);
    int n, k, budget, run_len, gap, pronto_k, pronto_n, most_n, max_end, wraps, prev_end, extra;
    logic [3:0] prev_leds, run_val;
    bit seen_run;
    entrada_t e;
    n     = lim + 1;
    extra = (pause_at > 0) ? 10 : 0;
    for (int i = 0; i < n; i++) begin
      e.val = rom[i];
      e.len = (i == 0) ? ta + extra : ta;
      sb.push_back(e);
    end
    budget = 1 + n * (ta + tb) + 2 * (n - 1) + extra + 20;
    if (pulse) begin
      @(negedge clock);
      set_lim(AW'(lim));
      set_ini(1'b1);
      @(negedge clock);
      set_ini(hold);
    end
    prev_leds = '0; run_val = '0; run_len = 0; gap = 0; seen_run = 1'b0;
    pronto_k = -1; pronto_n = 0; most_n = 0; max_end = 0; wraps = 0; prev_end = 0;
    k = 0;
    while (k < budget) begin
      if (k == 2) set_lim(~AW'(lim));
`ifdef MOSTRA_PAUSA_EN
      if (pause_at > 0 && k == pause_at)      bus0.pausa = 1'b1;
      if (pause_at > 0 && k == pause_at + 10) bus0.pausa = 1'b0;
`endif
      if (s_leds != 4'd0) begin
        if (prev_leds == 4'd0) begin
          if (seen_run) chk("dark_gap", 32'(gap), 32'(tb + 2));
          run_val = s_leds;
          run_len = 1;
        end else begin
          run_len++;
        end
      end else if (prev_leds != 4'd0) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL extra_entry observed=%0h expected=none", run_val);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("entry_val", 32'(run_val), 32'(e.val));
          chk("entry_len", 32'(run_len), 32'(e.len));
        end
        seen_run = 1'b1;
        gap = 1;
      end else if (seen_run) begin
        gap++;
      end
      prev_leds = s_leds;
      if (s_most) most_n++;
      if (s_pronto) begin
        pronto_n++;
        if (pronto_k < 0) pronto_k = k;
        set_lim(AW'(lim));
      end
      if (int'(s_end) > max_end)  max_end = int'(s_end);
      if (int'(s_end) < prev_end) wraps++;
      prev_end = int'(s_end);
      if (pronto_n > 0 && s_estado == 4'd0) break;
      @(negedge clock);
      k++;
    end
    chk("within_budget", 32'(k < budget), 32'd1);
    chk("entries_left", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("pronto_count", 32'(pronto_n), 32'd1);
    chk("pronto_cycle", 32'(pronto_k), 32'(1 + n * (ta + tb) + 2 * (n - 1) + extra));
    chk("mostrando_cycles", 32'(most_n), 32'(1 + n * (ta + tb) + 2 * (n - 1) + extra));
    chk("max_addr", 32'(max_end), 32'(lim));
    chk("addr_wrap", 32'(wraps), 32'd0);
    chk("final_state", 32'(s_estado), 32'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    rom[0] = 4'h5; rom[1] = 4'hA; rom[2] = 4'hA; rom[3] = 4'h3;
    reset = 1'b0;
    bus0.iniciar = 1'b0; bus0.limite = '0;
    bus1.iniciar = 1'b0; bus1.limite = '0;
`ifdef MOSTRA_PAUSA_EN
    bus0.pausa = 1'b0;
    bus1.pausa = 1'b0;
`endif
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_leds", 32'(bus0.leds), 32'd0);
    chk("rst_estado", 32'(bus0.db_estado), 32'd0);
    chk("rst_endereco", 32'(bus0.mem_endereco), 32'd0);
    chk("rst_pronto", 32'(bus0.pronto), 32'd0);
    chk("rst_mostrando", 32'(bus0.mostrando), 32'd0);
    chk("rst1_estado", 32'(bus1.db_estado), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Basic 3-entry sequence (5, A, A)
    sel = 1'b0;
    run_seq(1'b1, 1'b0, 2, A0, B0, 0);

    // Asynchronous reset during the second lit entry
    @(negedge clock);
    set_lim(AW'(2));
    set_ini(1'b1);
    @(negedge clock);
    set_ini(1'b0);
    w = 0;
    while (s_leds != 4'hA && w < 40) begin
      @(negedge clock);
      w++;
    end
    chk("second_acende_reached", 32'(w < 40), 32'd1);
    chk("second_acende_addr", 32'(s_end), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_leds", 32'(s_leds), 32'd0);
    chk("async_rst_estado", 32'(s_estado), 32'd0);
    chk("async_rst_mostrando", 32'(s_most), 32'd0);
    chk("async_rst_pronto", 32'(s_pronto), 32'd0);
    repeat (3) @(negedge clock);
    chk("rst_hold_pronto", 32'(s_pronto), 32'd0);
    reset = 1'b1;

    // Restart after reset with limite=0: single entry from address 0
    run_seq(1'b1, 1'b0, 0, A0, B0, 0);

    // iniciar held high: mid-sequence ignored, immediate restart after INICIAL
    run_seq(1'b1, 1'b1, 2, A0, B0, 0);
    @(negedge clock);
    chk("hold_restart", 32'(s_estado), 32'd1);
    set_ini(1'b0);
    run_seq(1'b0, 1'b0, 2, A0, B0, 0);

    // Full memory walk on the A=1/B=1 instance
    sel = 1'b1;
    run_seq(1'b1, 1'b0, 15, A1, B1, 0);
    sel = 1'b0;

`ifdef MOSTRA_PAUSA_EN
    // Pause 10 cycles inside the first lit interval
    run_seq(1'b1, 1'b0, 2, A0, B0, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
